// File: rtl/qnigma_math_chacha20_block.sv
// ChaCha20 block-function sequencer: builds the 16-word state, steps an external
// quarter-round engine through every round, then feeds forward through its adder.
module qnigma_math_chacha20_block #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] ks,
  output logic         qr_ld,
  output logic         qr_run,
  output logic [31:0]  qr_a_i,
  output logic [31:0]  qr_b_i,
  output logic [31:0]  qr_c_i,
  output logic [31:0]  qr_d_i,
  input  logic [31:0]  qr_a_o,
  input  logic [31:0]  qr_b_o,
  input  logic [31:0]  qr_c_o,
  input  logic [31:0]  qr_d_o,
  output logic [31:0]  qr_a,
  output logic [31:0]  qr_b,
  input  logic [31:0]  qr_q
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned R_W    = 5;
  localparam logic [R_W-1:0] LAST_R = R_W'(2 * DOUBLE_ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WB, ADD, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              busy_next;
  logic              valid_next;
  logic              ld_next;
  logic              run_next;

  logic [WORD_W-1:0] x0   [NWORDS];
  logic [WORD_W-1:0] w    [NWORDS];
  logic [WORD_W-1:0] init [NWORDS];
  logic [R_W-1:0]    r;
  logic [1:0]        k;
  logic [2:0]        t;
  logic [3:0]        i;

  logic [1:0]        kb, kc, kd;
  logic [3:0]        ia, ib, ic, id;
  logic [WORD_W-1:0] a_hold, b_hold, c_hold, d_hold;

  // Diagonal rounds rotate rows 1..3 by 1..3 words; column rounds take them straight.
  assign kb = r[0] ? 2'(k + 2'd1) : k;
  assign kc = r[0] ? 2'(k + 2'd2) : k;
  assign kd = r[0] ? 2'(k + 2'd3) : k;
  assign ia = {2'b00, k};
  assign ib = {2'b01, kb};
  assign ic = {2'b10, kc};
  assign id = {2'b11, kd};

  always_comb begin
    init[0] = 32'h6170_7865;
    init[1] = 32'h3320_646e;
    init[2] = 32'h7962_2d32;
    init[3] = 32'h6b20_6574;
    for (int n = 0; n < 8; n++) init[4 + n] = key[32*n +: 32];
    init[12] = counter;
    for (int n = 0; n < 3; n++) init[13 + n] = nonce[32*n +: 32];
  end

  // Engine load words are live in LOAD and frozen at their last value elsewhere.
  assign qr_a_i = (state == LOAD) ? w[ia] : a_hold;
  assign qr_b_i = (state == LOAD) ? w[ib] : b_hold;
  assign qr_c_i = (state == LOAD) ? w[ic] : c_hold;
  assign qr_d_i = (state == LOAD) ? w[id] : d_hold;

  assign qr_a = (state == ADD) ? w[i]  : '0;
  assign qr_b = (state == ADD) ? x0[i] : '0;

  // State register and registered handshake/engine controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ks_valid <= 1'b0;
      qr_ld    <= 1'b1;
      qr_run   <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= busy_next;
      ks_valid <= valid_next;
      qr_ld    <= ld_next;
      qr_run   <= run_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN:  if (t == 3'd7) state_next = WB;
      WB:   state_next = ((k != 2'd3) || (r != LAST_R)) ? LOAD : ADD;
      ADD:  if (i == 4'd15) state_next = DONE;
      DONE: if (ks_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next  = 1'b0;
    valid_next = 1'b0;
    ld_next    = 1'b0;
    run_next   = 1'b0;
    unique case (state_next)
      IDLE:    ld_next    = 1'b1;
      LOAD:    begin ld_next = 1'b1; busy_next = 1'b1; end
      RUN:     begin run_next = 1'b1; busy_next = 1'b1; end
      WB, ADD: busy_next  = 1'b1;
      DONE:    valid_next = 1'b1;
      default: ld_next    = 1'b1;
    endcase
  end

  // Working state, round counters and keystream accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NWORDS; n++) begin
        x0[n] <= '0;
        w[n]  <= '0;
      end
      r      <= '0;
      k      <= '0;
      t      <= '0;
      i      <= '0;
      ks     <= '0;
      a_hold <= '0;
      b_hold <= '0;
      c_hold <= '0;
      d_hold <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          for (int n = 0; n < NWORDS; n++) begin
            x0[n] <= init[n];
            w[n]  <= init[n];
          end
          r <= '0;
          k <= '0;
          i <= '0;
        end
        LOAD: begin
          a_hold <= w[ia];
          b_hold <= w[ib];
          c_hold <= w[ic];
          d_hold <= w[id];
          t      <= '0;
        end
        RUN: t <= t + 3'd1;
        WB: begin
          w[ia] <= qr_a_o;
          w[ib] <= qr_b_o;
          w[ic] <= qr_c_o;
          w[id] <= qr_d_o;
          if (k != 2'd3) begin
            k <= k + 2'd1;
          end else begin
            k <= '0;
            r <= (r != LAST_R) ? r + R_W'(1) : '0;
          end
        end
        ADD: begin
          ks[{i, 5'd0} +: 32] <= qr_q;
          i                   <= i + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
